match_logger: RTL and testbench

MATCH_LOGGER -- requirements
Module: match_logger

---
 rtl/match_logger_pkg.sv | 15 +
 rtl/match_logger_ring_ctr.sv | 56 +++++
 rtl/match_logger.sv | 177 +++++++++++++++++
 tb/tb_match_logger.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_logger_pkg.sv
// Shared definitions for the match logger: FSM state encoding and the
// widths of the record word, the ring occupancy count and the drop counter.
package match_logger_pkg;

  localparam int REC_W = 32;
  localparam int OVF_W = 16;
  localparam int CNT_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/match_logger_ring_ctr.sv
// Ring bookkeeping for the match logger: write pointer (wraps modulo DEPTH),
// occupancy count and full flag. inc_i commits one written slot, dec_i
// retires the oldest slot; a retire on an empty ring is ignored and a
// simultaneous commit/retire leaves the occupancy unchanged.
module match_logger_ring_ctr
  import match_logger_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             dec_ok;

  assign dec_ok = dec_i && (count_q != '0);

  // Next occupancy from commit/retire pulses
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_i && dec_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer, occupancy and full flag registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (inc_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full_q;

endmodule

// File: rtl/match_logger.sv
// Match logger: appends 32-bit records from the packet controller into a
// memory ring over Avalon-MM, one write at a time, with a one-deep pending
// slot for requests that arrive while a write is in flight. Records that
// cannot be held or stored (pending occupied, ring full) are counted in a
// saturating drop counter.
// Optional build macro MATCH_LOGGER_TIMESTAMP_EN: replaces the upper half of
// each record with a free-running 16-bit cycle stamp taken at log_req.
module match_logger
  import match_logger_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             log_req,
  input  logic [REC_W-1:0] log_data,
  input  logic             rd_inc,
  input  logic             avm_waitrequest,
  output logic             avm_write,
  output logic [31:0]      avm_address,
  output logic [REC_W-1:0] avm_writedata,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic [OVF_W-1:0] overflow_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [REC_W-1:0] pend_data_q, pend_data_d;
  logic             avm_write_q, avm_write_d;
  logic [31:0]      addr_q, addr_d;
  logic [REC_W-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [REC_W-1:0] rec_in;
  logic             slot_commit;
  logic [PTR_W-1:0] wr_ptr;
  logic             ring_full;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == {OVF_W{1'b1}}) ? v : v + OVF_W'(1);
  endfunction

  function automatic logic [31:0] slot_addr(input logic [PTR_W-1:0] p);
    return BASE_ADDR + {{(32-PTR_W-2){1'b0}}, p, 2'b00};
  endfunction

`ifdef MATCH_LOGGER_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running cycle stamp attached to each record
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;
    end
  end

  assign rec_in = {ts_q, log_data[15:0]};
`else
  assign rec_in = log_data;
`endif

  // A slot is committed to the ring in the DONE cycle
  assign slot_commit = (state_q == ST_DONE);

  match_logger_ring_ctr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ring_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .inc_i    (slot_commit),
    .dec_i    (rd_inc),
    .wr_ptr_o (wr_ptr),
    .count_o  (count),
    .full_o   (ring_full)
  );

  // Next-state: bus sequencing, pending slot and drop accounting
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    avm_write_d = avm_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        // The held record is older, so it is served before a fresh request
        if (pend_vld_q || log_req) begin
          if (ring_full) begin
            ovf_d = sat_inc(ovf_q);
          end else begin
            state_d     = ST_WRITE;
            avm_write_d = 1'b1;
            addr_d      = slot_addr(wr_ptr);
            wdata_d     = pend_vld_q ? pend_data_q : rec_in;
          end
        end
        // Pending slot is freed this cycle; a simultaneous request refills it
        if (pend_vld_q) begin
          pend_vld_d = log_req;
          if (log_req) begin
            pend_data_d = rec_in;
          end
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          state_d     = ST_DONE;
          avm_write_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        avm_write_d = 1'b0;
      end
    endcase

    // Requests during a transfer are parked, or dropped if the slot is taken
    if ((state_q != ST_IDLE) && log_req) begin
      if (pend_vld_q) begin
        ovf_d = sat_inc(ovf_q);
      end else begin
        pend_vld_d  = 1'b1;
        pend_data_d = rec_in;
      end
    end
  end

  assign busy_d = (state_d != ST_IDLE) || pend_vld_d;

  // FSM state and registered bus/status outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      pend_vld_q  <= 1'b0;
      avm_write_q <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      avm_write_q <= avm_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  // Pending record payload; only meaningful while pend_vld_q is set
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
  end

  assign avm_write     = avm_write_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign busy          = busy_q;
  assign full          = ring_full;
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_match_logger.sv
// Bench for match_logger (DEPTH=4, non-zero base). Expected bus writes are
// queued by the stimulus process; a monitor compares every cycle in which
// avm_write is high against the queue head and pops on acceptance.
module tb_match_logger;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        log_req;
  logic [31:0] log_data;
  logic        rd_inc;
  logic        avm_waitrequest;
  logic        avm_write;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic        busy;
  logic [12:0] count;
  logic        full;
  logic [15:0] overflow_cnt;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  match_logger #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .log_req         (log_req),
    .log_data        (log_data),
    .rd_inc          (rd_inc),
    .avm_waitrequest (avm_waitrequest),
    .avm_write       (avm_write),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .busy            (busy),
    .count           (count),
    .full            (full),
    .overflow_cnt    (overflow_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Single-cycle request followed by enough cycles to finish an unstalled write
  task automatic log_one(input logic [31:0] d);
    log_req  = 1'b1;
    log_data = d;
    tick();
    log_req  = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every driven bus cycle must match the oldest expected write
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && avm_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   avm_address, avm_writedata);
        end else begin
          chk("wr_addr", avm_address, exp_q[0].addr);
          chk("wr_data", avm_writedata, exp_q[0].data);
          if (avm_waitrequest === 1'b0) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst           = 1'b0;
    log_req         = 1'b0;
    log_data        = '0;
    rd_inc          = 1'b0;
    avm_waitrequest = 1'b0;

    // Reset values
    #12;
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_data", avm_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow_cnt, 0);
    tick();
    n_rst = 1'b1;

    // Single write, latency 1, count visible two cycles after the strobe
    log_req  = 1'b1;
    log_data = 32'hDEAD_BEEF;
    expect_write(BASE, 32'hDEAD_BEEF);
    tick();
    log_req = 1'b0;
    chk("lat_write", avm_write, 1);
    chk("lat_addr", avm_address, BASE);
    tick();
    chk("lat_write_low", avm_write, 0);
    chk("lat_busy_done", busy, 1);
    chk("lat_count_pre", count, 0);
    tick();
    chk("lat_count", count, 1);
    chk("lat_busy_idle", busy, 0);

    // Stalled write: held stable for 5 stall cycles plus the accept cycle
    avm_waitrequest = 1'b1;
    log_req         = 1'b1;
    log_data        = 32'h1234_5678;
    expect_write(BASE + 32'd4, 32'h1234_5678);
    tick();
    log_req = 1'b0;
    repeat (5) tick();
    avm_waitrequest = 1'b0;
    tick();
    chk("stall_write_low", avm_write, 0);
    tick();
    chk("stall_count", count, 2);

    // Retire coincident with commit leaves count, retire on empty ignored
    log_req  = 1'b1;
    log_data = 32'hA5A5_0003;
    expect_write(BASE + 32'd8, 32'hA5A5_0003);
    tick();
    log_req = 1'b0;
    tick();
    rd_inc = 1'b1;
    tick();
    rd_inc = 1'b0;
    chk("rdinc_done_count", count, 2);
    rd_inc = 1'b1;
    repeat (3) tick();
    rd_inc = 1'b0;
    chk("rdinc_empty_count", count, 0);
    chk("rdinc_empty_full", full, 0);

    // Three back-to-back requests under stall: 1 written, 2 parked, 3 dropped
    avm_waitrequest = 1'b1;
    log_req  = 1'b1;
    log_data = 32'h0000_0011;
    expect_write(BASE + 32'd12, 32'h0000_0011);
    tick();
    log_data = 32'h0000_0022;
    expect_write(BASE, 32'h0000_0022);
    tick();
    log_data = 32'h0000_0033;
    tick();
    log_req = 1'b0;
    chk("b2b_ovf", overflow_cnt, 1);
    chk("b2b_busy", busy, 1);
    tick();
    avm_waitrequest = 1'b0;
    repeat (6) tick();
    chk("b2b_count", count, 2);
    chk("b2b_ovf_hold", overflow_cnt, 1);
    chk("b2b_busy_end", busy, 0);

    // Fresh ring: fill, drop when full, then retire one and wrap to slot 0
    n_rst = 1'b0;
    #1;
    chk("rst2_ovf", overflow_cnt, 0);
    chk("rst2_count", count, 0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      expect_write(BASE + 32'(4 * i), 32'hC000_0000 + 32'(i));
      log_one(32'hC000_0000 + 32'(i));
    end
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    log_req  = 1'b1;
    log_data = 32'hBAD0_BAD0;
    tick();
    log_req = 1'b0;
    chk("full_drop_ovf", overflow_cnt, 1);
    chk("full_drop_write", avm_write, 0);
    chk("full_drop_busy", busy, 0);
    tick();
    chk("full_drop_count", count, 4);
    rd_inc = 1'b1;
    tick();
    rd_inc = 1'b0;
    chk("full_rd_count", count, 3);
    chk("full_rd_full", full, 0);
    expect_write(BASE, 32'hC0DE_0004);
    log_one(32'hC0DE_0004);
    chk("wrap_count", count, 4);
    chk("wrap_full", full, 1);

    // Reset in the middle of a stalled write
    rd_inc = 1'b1;
    tick();
    rd_inc          = 1'b0;
    avm_waitrequest = 1'b1;
    log_req         = 1'b1;
    log_data        = 32'h7777_0001;
    expect_write(BASE + 32'd4, 32'h7777_0001);
    tick();
    log_req = 1'b0;
    chk("midrst_write_pre", avm_write, 1);
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_write", avm_write, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ovf", overflow_cnt, 0);
    chk("midrst_full", full, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", avm_address, BASE);
    avm_waitrequest = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_write", avm_write, 0);
    chk("post_rst_busy", busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
